// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU-sharing controller: FSM encoding, ALU opcodes,
// response flag bit positions and the opcode legality check used by ALU_SHARE_OPCHK_EN.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // rsp_flags = {err, overflow, cout, zero}
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_COUT = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_ERR  = 3;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above rr_ptr, wrapping around. The pointer itself lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one registered 32-bit ALU among NREQ requesters.
// Optional macro ALU_SHARE_OPCHK_EN rejects illegal opcodes without using the ALU.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2   // 2**IDW must be >= NREQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic [3:0]           alu_ctrl,
  output logic [31:0]          alu_src1,
  output logic [31:0]          alu_src2,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_cout,
  input  logic                 alu_overflow,
  output logic                 busy
);

  state_t          state, state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [3:0]      sel_op;
  logic [31:0]     sel_a, sel_b;
  logic            op_ok;

  // Gated by rst_n so req_ready stays low while reset is held.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    ((state == IDLE) && rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;
  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign sel_op    = req_op[4*grant_idx +: 4];
  assign sel_a     = req_a[32*grant_idx +: 32];
  assign sel_b     = req_b[32*grant_idx +: 32];

`ifdef ALU_SHARE_OPCHK_EN
  assign op_ok = op_legal(sel_op);
`else
  assign op_ok = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = op_ok ? ISSUE : RESP;
      ISSUE:   state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      alu_ctrl   <= '0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_any) begin
        rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        rsp_id <= grant_idx;
        if (op_ok) begin
          alu_ctrl <= sel_op;
          alu_src1 <= sel_a;
          alu_src2 <= sel_b;
        end else begin
          // Rejected opcode: answer directly, ALU inputs untouched.
          rsp_result           <= '0;
          rsp_flags            <= '0;
          rsp_flags[FLAG_ERR]  <= 1'b1;
          rsp_valid            <= 1'b1;
        end
      end
      if (state == EXEC) begin
        rsp_result           <= alu_result;
        rsp_flags[FLAG_ERR]  <= 1'b0;
        rsp_flags[FLAG_OVF]  <= alu_overflow;
        rsp_flags[FLAG_COUT] <= alu_cout;
        rsp_flags[FLAG_ZERO] <= alu_zero;
        rsp_valid            <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one 32-bit registered ALU (4-bit ALU_control, result/zero/cout/overflow registered on the clk rising edge) among NREQ requesters.
- Round-robin arbitration; each accepted operation is sequenced through the ALU, and the flags are captured and returned to the originating requester over a valid/ready response channel.
- Sits between the core's execution clients (e.g. address calc, branch compare) and the shared ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_op  input  4*NREQ  ALU_control per requester; slice i = bits [4i+3:4i].
- req_a  input  32*NREQ  src1 per requester; slice i = bits [32i+31:32i].
- req_b  input  32*NREQ  src2 per requester; same slicing.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_result  output  32  ALU result.
- rsp_flags  output  4  {err, overflow, cout, zero}.
- alu_ctrl  output  4  to ALU ALU_control.
- alu_src1  output  32  to ALU src1.
- alu_src2  output  32  to ALU src2.
- alu_result  input  32  from ALU.
- alu_zero  input  1  from ALU.
- alu_cout  input  1  from ALU.
- alu_overflow  input  1  from ALU.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0; state=IDLE; rr_ptr=0.
  - alu_ctrl/alu_src1/alu_src2 held at 0.
- FSM states: IDLE -> ISSUE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap-around.
  - req_ready[grant]=1 combinationally this cycle; the handshake completes on this edge.
  - On that edge: latch op/a/b into alu_ctrl/alu_src1/alu_src2 registers, latch id; go to ISSUE.
  - rr_ptr <= grant+1 (wrap modulo NREQ).
- ISSUE: ALU inputs are stable; the ALU samples them on the edge ending this cycle. Go to EXEC.
- EXEC:
  - The ALU's registered outputs are valid.
  - Capture rsp_result=alu_result and rsp_flags={0, alu_overflow, alu_cout, alu_zero}.
  - Set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: clear rsp_valid, go to IDLE.
  - No new grant is issued in the same cycle; minimum spacing between grants is 4 cycles.
- Latency: 3 clk edges from the req handshake to rsp_valid (plus any response stall).
- req_ready is 0 in every state except IDLE.
- A requester that drops req_valid before being granted is simply skipped.
- ALU inputs keep their last values outside ISSUE/EXEC; there is no glitch back to 0.
- Only one operation is in flight; there is no pipelining.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.
- Mid-operation reset: immediate return to IDLE, rsp_valid=0, and the captured operation is discarded.
- cout/overflow are forwarded as the ALU reports them; they are meaningful only for add/sub (ALU_control[1:0]=2'b10). The controller does not mask them.

Optional Feature:
- Macro: ALU_SHARE_OPCHK_EN.
- Defined:
  - Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - On an illegal req_op the grant still handshakes, but the FSM goes IDLE -> RESP directly, bypassing the ALU; ALU inputs are unchanged.
  - Response: rsp_result=0, rsp_flags=4'b1000, rsp_valid asserted on the cycle after the grant.
- Not defined: every opcode is passed to the ALU, and err is always 0.

Decomposition:
- Package/header alu_share_pkg: state encoding constants (IDLE=2'd0, ISSUE=2'd1, EXEC=2'd2, RESP=2'd3), the six ALU_control opcode constants, and flag bit-position constants.
- Sub-module rr_arbiter: inputs req vector, rr_ptr, enable; outputs a one-hot grant plus an encoded index. Purely combinational; holds no pointer state.

Test Plan:
- Single request: requester 2, op=0010, a=5, b=7 -> granted idle cycle; rsp_valid 3 edges later; rsp_id=2, result=12, flags=0000.
- SUB to zero: a=b=0x8000_0000, op=0110 -> result=0, zero=1.
- SUB with overflow: a=0x8000_0000, b=1, op=0110 -> result=0x7FFF_FFFF, overflow=1.
- All four requesters valid continuously -> grant order 0,1,2,3,0; gap between grants is exactly 4 cycles.
- rsp_ready held low for 5 cycles -> rsp_* stable throughout; no req_ready asserted; after the accept, the next grant goes to the rr_ptr successor.
- Reset asserted during EXEC -> rsp_valid=0, busy=0, rr_ptr=0 immediately.
- With ALU_SHARE_OPCHK_EN defined, op=1111 -> rsp_flags=1000, result=0, rsp_valid on the cycle after the grant, alu_ctrl unchanged.
